edge_event_ctrl: RTL and testbench

EDGE_EVENT_CTRL -- requirements
Module: edge_event_ctrl

---
 rtl/edge_pkg.sv | 17 +
 rtl/edge_event_chan.sv | 85 ++++++++
 rtl/edge_event_ctrl.sv | 121 ++++++++++++
 tb/tb_edge_event_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// Shared definitions for the edge event controller: mode encodings and
// the channel-index width helper.
package edge_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  // Width of a channel index; never narrower than one bit.
  function automatic int chw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/edge_event_chan.sv
// One monitored channel: synchronizer, hold flop, edge qualification and
// the pending/direction/overrun bookkeeping for that channel.
module edge_event_chan
  import edge_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       sig_i,
  input  logic       enable_i,
  input  logic [1:0] mode_i,
  input  logic       clr_i,
  input  logic       primed_i,
  input  logic       load_i,
  output logic       pending_o,
  output logic       rise_o,
  output logic       overrun_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic hold_q, hold_d;
  logic pending_q, pending_d;
  logic rise_q, rise_d;
  logic overrun_q, overrun_d;
  logic synced, is_edge, dir_allowed, qual;

  // Synchronizer and hold flops run regardless of enable so re-enabling never sees a stale level.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sig_i};
    hold_d = sync_q[SYNC_STAGES-1];
  end

  // Qualify an edge by enable, priming and the direction selected by the mode.
  always_comb begin
    synced      = sync_q[SYNC_STAGES-1];
    is_edge     = synced ^ hold_q;
    dir_allowed = synced ? (mode_i == EDGE_RISE || mode_i == EDGE_BOTH)
                         : (mode_i == EDGE_FALL || mode_i == EDGE_BOTH);
    qual        = primed_i & enable_i & is_edge & dir_allowed;
  end

  // Pending/overrun update: clear wins, a load frees the flag for a same-clock edge.
  always_comb begin
    pending_d = pending_q;
    rise_d    = rise_q;
    overrun_d = overrun_q;
    if (clr_i) begin
      pending_d = 1'b0;
      overrun_d = 1'b0;
    end else if (load_i) begin
      pending_d = qual;
      if (qual) rise_d = synced;
    end else if (qual) begin
      if (pending_q) begin
        overrun_d = 1'b1;
      end else begin
        pending_d = 1'b1;
        rise_d    = synced;
      end
    end
  end

  // Channel state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q    <= '0;
      hold_q    <= 1'b0;
      pending_q <= 1'b0;
      rise_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      hold_q    <= hold_d;
      pending_q <= pending_d;
      rise_q    <= rise_d;
      overrun_q <= overrun_d;
    end
  end

  assign pending_o = pending_q;
  assign rise_o    = rise_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/edge_event_ctrl.sv
// Edge event controller top: per-channel detectors, round-robin arbiter
// and a single valid/ready event slot.
module edge_event_ctrl
  import edge_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CHW         = chw(NUM_CH)
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [NUM_CH-1:0]   sig_i,
  input  logic [NUM_CH-1:0]   enable_i,
  input  logic [2*NUM_CH-1:0] mode_i,
  input  logic [NUM_CH-1:0]   clr_i,
  output logic                evt_valid_o,
  input  logic                evt_ready_i,
  output logic [CHW-1:0]      evt_ch_o,
  output logic                evt_rise_o,
  output logic [NUM_CH-1:0]   pending_o,
  output logic [NUM_CH-1:0]   overrun_o,
  output logic                irq_o
);

  localparam logic [2:0] PRIME_DONE = 3'(SYNC_STAGES + 1);

  logic [2:0]        prime_q, prime_d;
  logic              primed;
  logic              valid_q, valid_d;
  logic [CHW-1:0]    ch_q, ch_d;
  logic              rise_q, rise_d;
  logic [CHW-1:0]    ptr_q, ptr_d;
  logic              irq_q, irq_d;
  logic [NUM_CH-1:0] pending, rise_vec, load, req;
  logic [CHW-1:0]    grant, cand;
  logic              found;
  int                idx;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    edge_event_chan #(.SYNC_STAGES(SYNC_STAGES)) u_chan (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .sig_i     (sig_i[g]),
      .enable_i  (enable_i[g]),
      .mode_i    (mode_i[2*g +: 2]),
      .clr_i     (clr_i[g]),
      .primed_i  (primed),
      .load_i    (load[g]),
      .pending_o (pending[g]),
      .rise_o    (rise_vec[g]),
      .overrun_o (overrun_o[g])
    );
  end

  // Hold off detection until the synchronizer and hold flops have been refilled from sig_i.
  always_comb begin
    primed  = (prime_q == PRIME_DONE);
    prime_d = primed ? prime_q : prime_q + 3'd1;
  end

  // Round-robin arbiter and slot: a channel being cleared this clock is not eligible, so clear discards it.
  always_comb begin
    load    = '0;
    valid_d = valid_q;
    ch_d    = ch_q;
    rise_d  = rise_q;
    ptr_d   = ptr_q;
    found   = 1'b0;
    grant   = '0;
    cand    = '0;
    idx     = 0;
    req     = pending & ~clr_i;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      cand = CHW'(idx);
      if (!found && req[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
    if (!valid_q || evt_ready_i) begin
      if (found) begin
        valid_d     = 1'b1;
        ch_d        = grant;
        rise_d      = rise_vec[grant];
        load[grant] = 1'b1;
        ptr_d       = (grant == CHW'(NUM_CH - 1)) ? '0 : grant + 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end
    irq_d = (|pending) | valid_q;
  end

  // Slot, pointer, priming counter and interrupt registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      prime_q <= '0;
      valid_q <= 1'b0;
      ch_q    <= '0;
      rise_q  <= 1'b0;
      ptr_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      prime_q <= prime_d;
      valid_q <= valid_d;
      ch_q    <= ch_d;
      rise_q  <= rise_d;
      ptr_q   <= ptr_d;
      irq_q   <= irq_d;
    end
  end

  assign evt_valid_o = valid_q;
  assign evt_ch_o    = ch_q;
  assign evt_rise_o  = rise_q;
  assign pending_o   = pending;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_edge_event_ctrl.sv
// Self-checking bench for edge_event_ctrl: directed scenarios with fixed
// expectations plus a randomized run against a behavioural model.
module tb_edge_event_ctrl;

  localparam int NUM_CH = 4;
  localparam int SYNC   = 2;
  localparam int CHW    = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NUM_CH-1:0]   sig = '0;
  logic [NUM_CH-1:0]   en = '0;
  logic [2*NUM_CH-1:0] mode = '0;
  logic [NUM_CH-1:0]   clr = '0;
  logic                ready = 1'b0;
  logic                evt_valid;
  logic [CHW-1:0]      evt_ch;
  logic                evt_rise;
  logic [NUM_CH-1:0]   pending;
  logic [NUM_CH-1:0]   overrun;
  logic                irq;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  edge_event_ctrl #(.NUM_CH(NUM_CH), .SYNC_STAGES(SYNC), .CHW(CHW)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .sig_i       (sig),
    .enable_i    (en),
    .mode_i      (mode),
    .clr_i       (clr),
    .evt_valid_o (evt_valid),
    .evt_ready_i (ready),
    .evt_ch_o    (evt_ch),
    .evt_rise_o  (evt_rise),
    .pending_o   (pending),
    .overrun_o   (overrun),
    .irq_o       (irq)
  );

  // Reference model: sample history of sig_i, per-channel flags, one slot.
  logic [NUM_CH-1:0] hist[$];
  logic [NUM_CH-1:0] m_pend, m_dir, m_ovr;
  logic              m_valid, m_rise, m_irq;
  int                m_ch, m_ptr, m_age;

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k <= SYNC; k++) hist.push_back('0);
    m_pend = '0; m_dir = '0; m_ovr = '0;
    m_valid = 1'b0; m_rise = 1'b0; m_irq = 1'b0;
    m_ch = 0; m_ptr = 0; m_age = 0;
  endtask

  // One rising clock of the model, using the inputs in force at that edge.
  task automatic model_step();
    logic [NUM_CH-1:0] newv, oldv, q, old_dir;
    logic can, irq_n;
    int g;
    if (!rst_n) begin
      model_reset();
      return;
    end
    newv = hist[SYNC-1];
    oldv = hist[SYNC];
    for (int c = 0; c < NUM_CH; c++) begin
      q[c] = (m_age >= SYNC + 1) && en[c] && (newv[c] != oldv[c]) &&
             (newv[c] ? mode[2*c] : mode[2*c+1]);
    end
    irq_n = (|m_pend) | m_valid;
    can = !m_valid || ready;
    g = -1;
    if (can) begin
      for (int k = 0; k < NUM_CH; k++) begin
        int c;
        c = (m_ptr + k) % NUM_CH;
        if (g < 0 && m_pend[c] && !clr[c]) g = c;
      end
    end
    old_dir = m_dir;
    for (int c = 0; c < NUM_CH; c++) begin
      if (clr[c]) begin
        m_pend[c] = 1'b0;
        m_ovr[c]  = 1'b0;
      end else if (c == g) begin
        m_pend[c] = q[c];
        if (q[c]) m_dir[c] = newv[c];
      end else if (q[c]) begin
        if (m_pend[c]) m_ovr[c] = 1'b1;
        else begin
          m_pend[c] = 1'b1;
          m_dir[c]  = newv[c];
        end
      end
    end
    if (can) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_ch    = g;
        m_rise  = old_dir[g];
        m_ptr   = (g + 1) % NUM_CH;
      end else begin
        m_valid = 1'b0;
      end
    end
    m_irq = irq_n;
    hist.push_front(sig);
    void'(hist.pop_back());
    if (m_age < 1000) m_age++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic apply_reset(input logic [NUM_CH-1:0] sig_val);
    sig = sig_val; en = '0; mode = '0; clr = '0; ready = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    sig = '0; en = '0; mode = '0; clr = '0; ready = 1'b0;
    rst_n = 1'b0;
    tick();
    n_total++; if (evt_valid !== 1'b0) $display("[TB] FAIL reset_valid got %b want 0", evt_valid); else n_pass++;
    n_total++; if (evt_ch !== '0) $display("[TB] FAIL reset_ch got %0d want 0", evt_ch); else n_pass++;
    n_total++; if (evt_rise !== 1'b0) $display("[TB] FAIL reset_rise got %b want 0", evt_rise); else n_pass++;
    n_total++; if (pending !== '0) $display("[TB] FAIL reset_pending got %b want 0000", pending); else n_pass++;
    n_total++; if (overrun !== '0) $display("[TB] FAIL reset_overrun got %b want 0000", overrun); else n_pass++;
    n_total++; if (irq !== 1'b0) $display("[TB] FAIL reset_irq got %b want 0", irq); else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_single_rise();
    apply_reset('0);
    repeat (5) tick();
    en = 4'b0010; mode = 8'b0000_0100; ready = 1'b1;
    sig[1] = 1'b1;
    tick(); tick();
    n_total++; if (pending !== 4'b0000) $display("[TB] FAIL single_early_pending got %b want 0000", pending); else n_pass++;
    tick();
    n_total++; if (pending !== 4'b0010) $display("[TB] FAIL single_pending got %b want 0010", pending); else n_pass++;
    n_total++; if (evt_valid !== 1'b0) $display("[TB] FAIL single_valid_early got %b want 0", evt_valid); else n_pass++;
    tick();
    n_total++; if (evt_valid !== 1'b1) $display("[TB] FAIL single_valid got %b want 1", evt_valid); else n_pass++;
    n_total++; if (evt_ch !== 2'd1) $display("[TB] FAIL single_ch got %0d want 1", evt_ch); else n_pass++;
    n_total++; if (evt_rise !== 1'b1) $display("[TB] FAIL single_rise got %b want 1", evt_rise); else n_pass++;
    n_total++; if (pending !== 4'b0000) $display("[TB] FAIL single_pending_clr got %b want 0000", pending); else n_pass++;
    tick();
    n_total++; if (evt_valid !== 1'b0) $display("[TB] FAIL single_one_clock got %b want 0", evt_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    apply_reset('0);
    repeat (5) tick();
    en = 4'b1101; mode = 8'b0101_0001; ready = 1'b0;
    sig = 4'b1101;
    repeat (3) tick();
    n_total++; if (pending !== 4'b1101) $display("[TB] FAIL b2b_pending got %b want 1101", pending); else n_pass++;
    repeat (7) tick();
    n_total++; if (evt_valid !== 1'b1 || evt_ch !== 2'd0) $display("[TB] FAIL b2b_first got v=%b ch=%0d want v=1 ch=0", evt_valid, evt_ch); else n_pass++;
    n_total++; if (pending !== 4'b1100) $display("[TB] FAIL b2b_pending_rest got %b want 1100", pending); else n_pass++;
    ready = 1'b1;
    tick();
    n_total++; if (evt_valid !== 1'b1 || evt_ch !== 2'd2) $display("[TB] FAIL b2b_second got v=%b ch=%0d want v=1 ch=2", evt_valid, evt_ch); else n_pass++;
    tick();
    n_total++; if (evt_valid !== 1'b1 || evt_ch !== 2'd3) $display("[TB] FAIL b2b_third got v=%b ch=%0d want v=1 ch=3", evt_valid, evt_ch); else n_pass++;
    tick();
    n_total++; if (evt_valid !== 1'b0) $display("[TB] FAIL b2b_drained got %b want 0", evt_valid); else n_pass++;
    n_total++; if (overrun !== 4'b0000) $display("[TB] FAIL b2b_overrun got %b want 0000", overrun); else n_pass++;
  endtask

  // Drives ch2 through rise, fall, rise with ready low; counts cycles where the slot was not the first rising event.
  task automatic setup_overrun(output int unstable);
    unstable = 0;
    apply_reset('0);
    repeat (5) tick();
    en = 4'b0100; mode = 8'b0011_0000; ready = 1'b0;
    sig[2] = 1'b1;
    repeat (4) tick();
    sig[2] = 1'b0;
    repeat (4) begin
      tick();
      if (!(evt_valid === 1'b1 && evt_ch === 2'd2 && evt_rise === 1'b1)) unstable++;
    end
    sig[2] = 1'b1;
    repeat (6) begin
      tick();
      if (!(evt_valid === 1'b1 && evt_ch === 2'd2 && evt_rise === 1'b1)) unstable++;
    end
  endtask

  task automatic test_overrun();
    int unstable;
    setup_overrun(unstable);
    n_total++; if (unstable !== 0) $display("[TB] FAIL ovr_slot_stable got %0d unstable cycles want 0", unstable); else n_pass++;
    n_total++; if (pending !== 4'b0100) $display("[TB] FAIL ovr_pending got %b want 0100", pending); else n_pass++;
    n_total++; if (overrun !== 4'b0100) $display("[TB] FAIL ovr_flag got %b want 0100", overrun); else n_pass++;
    ready = 1'b1;
    tick();
    // The falling toggle set pending; the later rising toggle only marks overrun.
    n_total++; if (evt_valid !== 1'b1 || evt_ch !== 2'd2 || evt_rise !== 1'b0) $display("[TB] FAIL ovr_kept_dir got v=%b ch=%0d r=%b want v=1 ch=2 r=0", evt_valid, evt_ch, evt_rise); else n_pass++;
    n_total++; if (overrun !== 4'b0100) $display("[TB] FAIL ovr_sticky got %b want 0100", overrun); else n_pass++;
    tick();
    n_total++; if (evt_valid !== 1'b0) $display("[TB] FAIL ovr_drained got %b want 0", evt_valid); else n_pass++;
  endtask

  task automatic test_clear();
    int unstable;
    int extra;
    setup_overrun(unstable);
    clr = 4'b0100;
    tick();
    clr = '0;
    n_total++; if (pending !== 4'b0000) $display("[TB] FAIL clr_pending got %b want 0000", pending); else n_pass++;
    n_total++; if (overrun !== 4'b0000) $display("[TB] FAIL clr_overrun got %b want 0000", overrun); else n_pass++;
    n_total++; if (evt_valid !== 1'b1 || evt_ch !== 2'd2 || evt_rise !== 1'b1) $display("[TB] FAIL clr_slot_kept got v=%b ch=%0d r=%b want v=1 ch=2 r=1", evt_valid, evt_ch, evt_rise); else n_pass++;
    ready = 1'b1;
    tick();
    extra = 0;
    repeat (6) begin
      if (evt_valid === 1'b1) extra++;
      tick();
    end
    n_total++; if (extra !== 0) $display("[TB] FAIL clr_no_replay got %0d events want 0", extra); else n_pass++;
  endtask

  task automatic test_held_high();
    int seen;
    apply_reset(4'b0001);
    en = 4'b1111; mode = 8'hFF; ready = 1'b1;
    seen = 0;
    repeat (20) begin
      tick();
      if (evt_valid !== 1'b0 || pending !== '0) seen++;
    end
    n_total++; if (seen !== 0) $display("[TB] FAIL held_high_spurious got %0d cycles want 0", seen); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int seen;
    apply_reset('0);
    repeat (5) tick();
    en = 4'b1111; mode = 8'h55; ready = 1'b0;
    sig = 4'b0011;
    repeat (5) tick();
    n_total++; if (evt_valid !== 1'b1 || pending !== 4'b0010) $display("[TB] FAIL rmid_setup got v=%b p=%b want v=1 p=0010", evt_valid, pending); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if (evt_valid !== 1'b0) $display("[TB] FAIL rmid_valid got %b want 0", evt_valid); else n_pass++;
    n_total++; if (pending !== '0 || overrun !== '0 || irq !== 1'b0) $display("[TB] FAIL rmid_flags got p=%b o=%b i=%b want 0", pending, overrun, irq); else n_pass++;
    tick();
    rst_n = 1'b1;
    ready = 1'b1;
    seen = 0;
    repeat (20) begin
      tick();
      if (evt_valid !== 1'b0 || pending !== '0) seen++;
    end
    n_total++; if (seen !== 0) $display("[TB] FAIL rmid_replay got %0d cycles want 0", seen); else n_pass++;
  endtask

  task automatic test_random();
    int errs;
    rst_n = 1'b0; clr = '0; ready = 1'b0;
    tick();
    rst_n = 1'b1;
    errs = 0;
    for (int i = 0; i < 800; i++) begin
      sig   = sig ^ (NUM_CH'($urandom) & NUM_CH'($urandom));
      for (int c = 0; c < NUM_CH; c++) begin
        en[c]  = ($urandom_range(0, 7) != 0);
        clr[c] = ($urandom_range(0, 15) == 0);
      end
      if (i % 50 == 0) mode = (2*NUM_CH)'($urandom);
      ready = ($urandom_range(0, 2) != 0);
      if (i == 400) rst_n = 1'b0;
      if (i == 401) rst_n = 1'b1;
      tick();
      n_total++; if (evt_valid !== m_valid) begin errs++; if (errs < 20) $display("[TB] FAIL rnd_valid cyc %0d got %b want %b", i, evt_valid, m_valid); end else n_pass++;
      if (m_valid) begin
        n_total++; if (evt_ch !== CHW'(m_ch) || evt_rise !== m_rise) begin errs++; if (errs < 20) $display("[TB] FAIL rnd_event cyc %0d got ch=%0d r=%b want ch=%0d r=%b", i, evt_ch, evt_rise, m_ch, m_rise); end else n_pass++;
      end
      n_total++; if (pending !== m_pend) begin errs++; if (errs < 20) $display("[TB] FAIL rnd_pending cyc %0d got %b want %b", i, pending, m_pend); end else n_pass++;
      n_total++; if (overrun !== m_ovr) begin errs++; if (errs < 20) $display("[TB] FAIL rnd_overrun cyc %0d got %b want %b", i, overrun, m_ovr); end else n_pass++;
      n_total++; if (irq !== m_irq) begin errs++; if (errs < 20) $display("[TB] FAIL rnd_irq cyc %0d got %b want %b", i, irq, m_irq); end else n_pass++;
    end
  endtask

  initial begin
    model_reset();
    $display("[TB] edge_event_ctrl bench start");
    test_reset();
    test_single_rise();
    test_back_to_back();
    test_overrun();
    test_clear();
    test_held_high();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
